// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, response and RAM-port signals of the memory arbiter.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        bus_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, bus_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants instruction or data requests onto one RAM port, holding each grant
// until ACCESS, ERROR or timeout; data wins ties unless it won the previous grant.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam logic [31:0] ERR_DATA = 32'hBAD1BAD1;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t state, next_state, arb;
    logic [CNT_W-1:0] cnt;
    logic [31:0] lat_addr, lat_store, rdata;
    logic lat_rw, last_d, bus_err_q;
    logic dreq, granted, acc, timeout, err, done, grant, dwait, iwait;

    always_comb begin
        dreq       = bus.dREN | bus.dWEN;
        granted    = state != IDLE;
        acc        = granted && bus.ramstate == ACCESS;
        timeout    = granted && cnt == CNT_W'(TIMEOUT_CYCLES);
        err        = granted && !acc && (bus.ramstate == ERROR || timeout);
        done       = acc || err;
        arb        = (dreq && bus.iREN) ? (last_d ? IGRANT : DGRANT) :
                     dreq ? DGRANT : bus.iREN ? IGRANT : IDLE;
        next_state = (!granted || done) ? arb : state;
        grant      = (!granted || done) && arb != IDLE;
        dwait      = !(state == DGRANT && done);
        iwait      = !(state == IGRANT && done);
        rdata      = err ? ERR_DATA : bus.ramload;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_rw    <= 1'b0;
            last_d    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= next_state;
            bus_err_q <= err;
            if (grant) begin
                cnt       <= '0;
                lat_addr  <= arb == DGRANT ? bus.daddr : bus.iaddr;
                lat_store <= bus.dstore;
                lat_rw    <= bus.dWEN;
                last_d    <= arb == DGRANT;
            end else if (granted && !done) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // strobes come only from state and latched rw, and fall during the timeout abort cycle
    assign bus.ramREN   = !timeout && (state == IGRANT || (state == DGRANT && !lat_rw));
    assign bus.ramWEN   = !timeout && state == DGRANT && lat_rw;
    assign bus.ramaddr  = lat_addr;
    assign bus.ramstore = lat_store;
    assign bus.dwait    = dwait;
    assign bus.iwait    = iwait;
    assign bus.dload    = dwait ? '0 : rdata;
    assign bus.iload    = iwait ? '0 : rdata;
    assign bus.bus_err  = bus_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a completion scoreboard checked by a negedge monitor.
module tb_mem_arbiter;
    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    logic berr_exp = 1'b0;
    int hi;

    mem_arbiter_if bus();

    mem_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        logic [31:0] ld;
        tests++;
        if (bus.bus_err !== berr_exp) begin
            fails++;
            $display("FAIL bus_err: got %b expected %b at %0t", bus.bus_err, berr_exp, $time);
        end
        berr_exp = 1'b0;
        tests++;
        if ((bus.dwait && bus.dload !== 32'h0) || (bus.iwait && bus.iload !== 32'h0)) begin
            fails++;
            $display("FAIL load_zero: got d=%h i=%h expected 0 at %0t", bus.dload, bus.iload, $time);
        end
        if (!RST && (!bus.dwait || !bus.iwait)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL completion: got dwait=%b iwait=%b expected no completion at %0t",
                         bus.dwait, bus.iwait, $time);
            end else begin
                e  = sb.pop_front();
                ld = e.is_d ? bus.dload : bus.iload;
                if ({!bus.dwait, !bus.iwait} !== {e.is_d, !e.is_d} || ld !== e.data) begin
                    fails++;
                    $display("FAIL completion: got dwait=%b iwait=%b load=%h expected is_d=%b load=%h at %0t",
                             bus.dwait, bus.iwait, ld, e.is_d, e.data, $time);
                end
                berr_exp = e.err;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
        step(); step();
        #2;
        chk("rst_iwait", 32'(bus.iwait), 1);
        chk("rst_dwait", 32'(bus.dwait), 1);
        chk("rst_ramREN", 32'(bus.ramREN), 0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 0);
        RST = 0;

        // data read: 3 BUSY cycles then ACCESS
        step();
        bus.dREN = 1; bus.daddr = 32'h40; bus.ramstate = 2'd1;
        step();
        bus.dREN = 0;
        hi = 0;
        for (int n = 0; n < 4; n++) begin
            if (n == 3) begin
                bus.ramstate = 2'd2; bus.ramload = 32'h1234;
                sb.push_back('{1'b1, 32'h1234, 1'b0});
            end
            #2;
            hi += int'(bus.ramREN);
            if (n == 0) chk("rd_addr", bus.ramaddr, 32'h40);
            step();
        end
        bus.ramstate = 2'd0;
        #2;
        chk("rd_ren_cycles", 32'(hi), 4);
        chk("rd_idle_ren", 32'(bus.ramREN), 0);

        // simultaneous write and fetch from reset: D first, then I with no bubble
        RST = 1;
        step();
        RST = 0;
        bus.iREN = 1; bus.iaddr = 32'h100; bus.dWEN = 1; bus.daddr = 32'h200;
        bus.dstore = 32'hCAFE0001; bus.ramstate = 2'd2; bus.ramload = 32'h11;
        sb.push_back('{1'b1, 32'h11, 1'b0});
        step();
        #2;
        chk("wr_wen", 32'(bus.ramWEN), 1);
        chk("wr_ren", 32'(bus.ramREN), 0);
        chk("wr_addr", bus.ramaddr, 32'h200);
        chk("wr_store", bus.ramstore, 32'hCAFE0001);
        step();
        bus.dWEN = 0; bus.iREN = 0; bus.ramload = 32'h22;
        sb.push_back('{1'b0, 32'h22, 1'b0});
        #2;
        chk("if_ren", 32'(bus.ramREN), 1);
        chk("if_wen", 32'(bus.ramWEN), 0);
        chk("if_addr", bus.ramaddr, 32'h100);
        step();
        bus.ramstate = 2'd0;
        #2;
        chk("if_idle_ren", 32'(bus.ramREN), 0);

        // continuous contention: strict D,I,D,I alternation
        bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h5555;
        bus.iREN = 1; bus.iaddr = 32'h400; bus.ramstate = 2'd2;
        step();
        for (int j = 0; j < 6; j++) begin
            bus.ramload = 32'hA0 + 32'(j);
            sb.push_back('{(j % 2 == 0), 32'hA0 + 32'(j), 1'b0});
            #2;
            chk("alt_wen", 32'(bus.ramWEN), (j % 2 == 0) ? 1 : 0);
            chk("alt_addr", bus.ramaddr, (j % 2 == 0) ? 32'h300 : 32'h400);
            if (j == 5) begin bus.dWEN = 0; bus.iREN = 0; end
            step();
        end
        bus.ramstate = 2'd0;
        #2;
        chk("alt_idle_ren", 32'(bus.ramREN), 0);

        // timeout: RAM stuck BUSY
        bus.dREN = 1; bus.daddr = 32'h500; bus.ramstate = 2'd1;
        step();
        bus.dREN = 0;
        sb.push_back('{1'b1, 32'hBAD1BAD1, 1'b1});
        for (int n = 0; n < 255; n++) begin
            if (n == 0 || n == 254) begin
                #2;
                chk("to_ren_held", 32'(bus.ramREN), 1);
            end
            step();
        end
        #2;
        chk("to_ren_drop", 32'(bus.ramREN), 0);
        chk("to_dwait", 32'(bus.dwait), 0);
        step();
        #2;
        chk("to_idle_dwait", 32'(bus.dwait), 1);

        // RAM ERROR on an instruction fetch
        bus.iREN = 1; bus.iaddr = 32'h800; bus.ramstate = 2'd3;
        step();
        bus.iREN = 0;
        sb.push_back('{1'b0, 32'hBAD1BAD1, 1'b1});
        #2;
        chk("er_ren", 32'(bus.ramREN), 1);
        step();
        bus.ramstate = 2'd0;
        #2;
        chk("er_idle_iwait", 32'(bus.iwait), 1);

        // requester drops dREN mid-grant; latched address is kept
        bus.dREN = 1; bus.daddr = 32'h600; bus.ramstate = 2'd1;
        step();
        step();
        bus.dREN = 0; bus.daddr = 32'hFFFF_FFFF;
        #2;
        chk("drop_addr", bus.ramaddr, 32'h600);
        chk("drop_ren", 32'(bus.ramREN), 1);
        step();
        bus.ramstate = 2'd2; bus.ramload = 32'h77;
        sb.push_back('{1'b1, 32'h77, 1'b0});
        step();
        bus.ramstate = 2'd0;
        #2;
        chk("drop_idle_dwait", 32'(bus.dwait), 1);

        // async reset mid-IGRANT
        bus.iREN = 1; bus.iaddr = 32'h700; bus.ramstate = 2'd1;
        step();
        bus.iREN = 0;
        #2;
        chk("ar_ren_before", 32'(bus.ramREN), 1);
        RST = 1;
        #1;
        chk("ar_ren_async", 32'(bus.ramREN), 0);
        chk("ar_iwait", 32'(bus.iwait), 1);
        step(); step();
        RST = 0; bus.ramstate = 2'd0;
        step();
        #2;
        chk("ar_idle_ren", 32'(bus.ramREN), 0);
        chk("ar_bus_err", 32'(bus.bus_err), 0);

        step(); step();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
